otter_alu_mdu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle OTTER ALU.
- Executes the base RV integer ALU operations with a registered one-cycle latency.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an iterative radix-2 shift-add multiplier and a restoring divider.
- Sits in the execute stage; the control FSM stalls on ALU_busy and captures ALU_result on ALU_done.

---
 rtl/otter_alu_mdu.sv | 214 +++++++++++++++++++++
 tb/tb_otter_alu_mdu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_alu_mdu.sv
// otter_alu_mdu: registered RV integer ALU plus M-extension unit.
//   Base ops complete one cycle after acceptance. M ops run WIDTH iterations
//   of a radix-2 shift-add multiplier or a restoring divider on operand
//   magnitudes, with the sign applied when the result is written.
// Ports:
//   CLK, RST_n           clock, asynchronous active-low reset
//   ALU_start            request, sampled only while idle
//   ALU_mext             1 = M-extension op (ALU_fun[2:0] is funct3)
//   ALU_fun              base op code or {x, funct3}
//   ALU_srcA/ALU_srcB    operands, captured at acceptance
//   ALU_busy             high from the cycle after acceptance through done
//   ALU_done             one-cycle pulse, ALU_result valid from here on
//   ALU_result           registered result, held until the next done
module otter_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ALU_start,
  input  logic             ALU_mext,
  input  logic [3:0]       ALU_fun,
  input  logic [WIDTH-1:0] ALU_srcA,
  input  logic [WIDTH-1:0] ALU_srcB,
  output logic             ALU_busy,
  output logic             ALU_done,
  output logic [WIDTH-1:0] ALU_result
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 bzero_q, bzero_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;

  // Base ALU, evaluated on the live operands in the accepting cycle
  logic signed [WIDTH-1:0] a_sg, b_sg;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        base_res;

  assign a_sg  = ALU_srcA;
  assign b_sg  = ALU_srcB;
  assign shamt = ALU_srcB[SHW-1:0];

  always_comb begin
    case (ALU_fun)
      4'b0000: base_res = ALU_srcA + ALU_srcB;
      4'b1000: base_res = ALU_srcA - ALU_srcB;
      4'b0111: base_res = ALU_srcA & ALU_srcB;
      4'b0110: base_res = ALU_srcA | ALU_srcB;
      4'b0100: base_res = ALU_srcA ^ ALU_srcB;
      4'b0001: base_res = ALU_srcA << shamt;
      4'b0101: base_res = ALU_srcA >> shamt;
      4'b1101: base_res = a_sg >>> shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, (a_sg < b_sg)};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (ALU_srcA < ALU_srcB)};
      4'b1001: base_res = ALU_srcA;
      default: base_res = {(WIDTH/16){16'hBEEF}};
    endcase
  end

  // Operand conditioning for M ops: which operands are signed, their
  // magnitudes, and whether the final result must be negated.
  logic [2:0]       f3;
  logic             a_neg, b_neg, sgn_a, sgn_b, start_neg;
  logic [WIDTH-1:0] ma, mb;

  always_comb begin
    f3        = ALU_fun[2:0];
    a_neg     = ALU_srcA[WIDTH-1];
    b_neg     = ALU_srcB[WIDTH-1];
    sgn_a     = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    sgn_b     = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    ma        = neg_w(ALU_srcA, sgn_a & a_neg);
    mb        = neg_w(ALU_srcB, sgn_b & b_neg);
    start_neg = 1'b0;
    if ((f3 == 3'b001) || (f3 == 3'b100))      start_neg = a_neg ^ b_neg;
    else if ((f3 == 3'b010) || (f3 == 3'b110)) start_neg = a_neg;
  end

  // One iteration. Multiply: acc = {hi, multiplier}, add multiplicand to hi
  // when the low bit is set, then shift right with the carry. Divide:
  // acc = {remainder, dividend}, shift left and subtract divisor if it fits.
  logic [WIDTH:0]       mul_hi;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     diff;
  logic                 fits;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     m_res;

  always_comb begin
    mul_hi = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    fits   = rem_sh >= {1'b0, opnd_q};
    // The true difference is below the divisor, so WIDTH bits suffice.
    diff   = rem_sh[WIDTH-1:0] - opnd_q;
    if (op_q[2])
      acc_nx = fits ? {diff, acc_q[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_nx = {mul_hi, acc_q[WIDTH-1:1]};

    prod = neg_2w(acc_nx, neg_q);
    case (op_q)
      3'b000:                  m_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:  m_res = prod[2*WIDTH-1:WIDTH];
      // Magnitude division by zero already yields all ones; only the sign
      // fix-up would disturb it, so the zero-divisor quotient is forced.
      3'b100, 3'b101:          m_res = bzero_q ? '1 : neg_w(acc_nx[WIDTH-1:0], neg_q);
      default:                 m_res = neg_w(acc_nx[2*WIDTH-1:WIDTH], neg_q);
    endcase
  end

  // Control: done and result are registered on entry to FIN, so the done
  // cycle is the FIN cycle and a start seen there is not accepted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (ALU_start) begin
          busy_d = 1'b1;
          if (ALU_mext) begin
            state_d = S_CALC;
            cnt_d   = '0;
            op_d    = f3;
            neg_d   = start_neg;
            bzero_d = (ALU_srcB == '0);
            if (f3[2]) begin
              acc_d  = {{WIDTH{1'b0}}, ma};
              opnd_d = mb;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, mb};
              opnd_d = ma;
            end
          end else begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = base_res;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          result_d = m_res;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ALU_busy   = busy_q;
  assign ALU_done   = done_q;
  assign ALU_result = result_q;

endmodule

// File: tb/tb_otter_alu_mdu.sv
// Testbench for otter_alu_mdu: a 32-bit and a 16-bit instance, directed and
// random operations checked against an arithmetic reference model.
module tb_otter_alu_mdu;
  logic        clk;
  logic        rst_n;
  logic        start, mext;
  logic [3:0]  fun;
  logic [31:0] a, b, res;
  logic        busy, done;
  logic        start16, mext16;
  logic [3:0]  fun16;
  logic [15:0] a16, b16, res16;
  logic        busy16, done16;

  int tests = 0;
  int fails = 0;

  otter_alu_mdu #(.WIDTH(32)) dut (
    .CLK(clk), .RST_n(rst_n), .ALU_start(start), .ALU_mext(mext), .ALU_fun(fun),
    .ALU_srcA(a), .ALU_srcB(b), .ALU_busy(busy), .ALU_done(done), .ALU_result(res)
  );

  otter_alu_mdu #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST_n(rst_n), .ALU_start(start16), .ALU_mext(mext16), .ALU_fun(fun16),
    .ALU_srcA(a16), .ALU_srcB(b16), .ALU_busy(busy16), .ALU_done(done16), .ALU_result(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [31:0] ref32(input bit m, input logic [3:0] f,
                                        input logic [31:0] xa, input logic [31:0] xb);
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = longint'({32'b0, xa});
    ub = longint'({32'b0, xb});
    if (!m) begin
      case (f)
        4'b0000: return xa + xb;
        4'b1000: return xa - xb;
        4'b0111: return xa & xb;
        4'b0110: return xa | xb;
        4'b0100: return xa ^ xb;
        4'b0001: return xa << xb[4:0];
        4'b0101: return xa >> xb[4:0];
        4'b1101: begin p = sa >>> xb[4:0]; return p[31:0]; end
        4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: return (ua < ub) ? 32'd1 : 32'd0;
        4'b1001: return xa;
        default: return 32'hBEEFBEEF;
      endcase
    end
    case (f[2:0])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, xa} * {32'b0, xb}; return pu[63:32]; end
      3'd4: begin if (xb == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (xb == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (xb == 0) return xa; p = sa % sb; return p[31:0]; end
      default: begin if (xb == 0) return xa; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Issue one op at a negedge, then check busy/done every cycle up to the
  // expected done cycle, the result, and the idle/hold cycle after it.
  // poke re-asserts start mid-calculation with scrambled operands.
  task automatic do_op(input bit m, input logic [3:0] f, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] e, input bit poke,
                       input string tag);
    int lat;
    lat = m ? 33 : 1;
    start = 1'b1; mext = m; fun = f; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; fun = 4'($urandom); mext = 1'($urandom);
    for (int k = 1; k <= lat; k++) begin
      chk({tag, " busy/done"}, 64'({busy, done}), 64'({1'b1, (k == lat)}));
      if (k == lat) chk({tag, " result"}, 64'(res), 64'(e));
      else begin
        start = (poke && k == 5);
        @(negedge clk);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, 64'({busy, done}), 64'd0);
    chk({tag, " hold"}, 64'(res), 64'(e));
  endtask

  task automatic do16(input bit m, input logic [3:0] f, input logic [15:0] xa,
                      input logic [15:0] xb, input logic [15:0] e, input string tag);
    int lat;
    lat = m ? 17 : 1;
    start16 = 1'b1; mext16 = m; fun16 = f; a16 = xa; b16 = xb;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    for (int k = 1; k <= lat; k++) begin
      chk({tag, " busy/done"}, 64'({busy16, done16}), 64'({1'b1, (k == lat)}));
      if (k == lat) chk({tag, " result"}, 64'(res16), 64'(e));
      else @(negedge clk);
    end
    @(negedge clk);
    chk({tag, " idle"}, 64'({busy16, done16}), 64'd0);
  endtask

  initial begin
    logic [31:0] ea[6];
    logic [31:0] eb[6];
    logic [31:0] prev, ra, rb;
    logic [3:0]  rf;
    bit          rm;
    int          seen;

    rst_n = 1'b0; start = 1'b0; mext = 1'b0; fun = 4'd0; a = '0; b = '0;
    start16 = 1'b0; mext16 = 1'b0; fun16 = 4'd0; a16 = '0; b16 = '0;
    prev = '0;
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Base ops
    do_op(0, 4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, "add");
    do_op(0, 4'b1000, 32'h0,        32'h1,        32'hFFFFFFFF, 0, "sub");
    do_op(0, 4'b1101, 32'h80000000, 32'h24,       32'hF8000000, 0, "sra");
    do_op(0, 4'b0011, 32'h1,        32'hFFFFFFFF, 32'h1,        0, "sltu");
    do_op(0, 4'b0010, 32'h1,        32'hFFFFFFFF, 32'h0,        0, "slt");
    do_op(0, 4'b1111, 32'h12345678, 32'h9,        32'hBEEFBEEF, 0, "bad code");

    // Multiply family; MUL also gets a start poked during CALC
    do_op(1, 4'b0000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1, "mul");
    do_op(1, 4'b0001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 0, "mulh");
    do_op(1, 4'b0011, 32'hFFFFFFFF, 32'h2, 32'h00000001, 0, "mulhu");
    do_op(1, 4'b1010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 0, "mulhsu");

    // Divide family and special cases
    do_op(1, 4'b0100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, "div");
    do_op(1, 4'b0110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, "rem");
    do_op(1, 4'b0101, 32'h7,        32'h0,        32'hFFFFFFFF, 0, "divu by 0");
    do_op(1, 4'b0111, 32'h7,        32'h0,        32'h00000007, 0, "remu by 0");
    do_op(1, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf");
    do_op(1, 4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, "rem ovf");
    do_op(1, 4'b0100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 0, "div by 0");

    // Start held high: adds accepted every other cycle
    start = 1'b1; mext = 1'b0; fun = 4'b0000;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        chk("b2b done", 64'(done), 64'(k % 2 == 1));
        if (k % 2 == 1) begin
          prev = ea[k-1] + eb[k-1];
          chk("b2b result", 64'(res), 64'(prev));
        end else chk("b2b stable", 64'(res), 64'(prev));
      end
      if (k < 6) begin
        ea[k] = $urandom; eb[k] = $urandom; a = ea[k]; b = eb[k];
        @(negedge clk);
      end else start = 1'b0;
    end
    @(negedge clk);

    // Random ops against the model, with divide corner cases mixed in
    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom); rf = 4'($urandom); ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      else if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = '1; end
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40)) - 32'd20;
      do_op(rm, rf, ra, rb, ref32(rm, rf, ra, rb), (i % 5 == 0), "random");
    end

    // Asynchronous reset in the middle of a multiply (counter 10)
    do_op(0, 4'b0110, 32'h00F0, 32'h0F00, 32'h0FF0, 0, "pre-reset or");
    start = 1'b1; mext = 1'b1; fun = 4'b0011; a = 32'hFFFF0000; b = 32'h12345;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    chk("mid reset result", 64'(res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    chk("no done after reset", 64'(seen), 64'd0);
    do_op(1, 4'b0000, 32'h00012345, 32'h00000100, 32'h01234500, 0, "post-reset mul");

    // 16-bit instance
    do16(1, 4'b0011, 16'hFFFF, 16'hFFFF, 16'hFFFE, "w16 mulhu");
    do16(0, 4'b0001, 16'h0001, 16'hFFF3, 16'h0008, "w16 sll");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
